// File: rtl/alu_share_sched_pkg.sv
// alu_share_pkg: opcode/state types and the shared add/sub/mul function for alu_share_sched.
// Rev 1.0
`default_nettype none

package alu_share_pkg;

    // Datapaths up to this width are supported by alu_calc; callers truncate to DW.
    localparam int unsigned CALC_W = 64;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_ILL = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    function automatic logic [CALC_W-1:0] alu_calc(
        input alu_op_e           op,
        input logic [CALC_W-1:0] a,
        input logic [CALC_W-1:0] b
    );
        logic [CALC_W-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_MUL:  r = a * b;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_share_sched_if.sv
// alu_share_sched_if: request/response bus between requesters and the shared ALU scheduler.
// Rev 1.0
`default_nettype none

interface alu_share_sched_if #(
    parameter int NREQ = 3,
    parameter int DW   = 32
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [2*NREQ-1:0]  req_op;
    logic [DW*NREQ-1:0] req_a;
    logic [DW*NREQ-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IW-1:0]      rsp_id;
    logic [DW-1:0]      rsp_data;
    logic               rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

endinterface

`default_nettype wire

// File: rtl/alu_share_sched_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first requester after ptr_i, one-hot grant plus index.
// Rev 1.0
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW   = $clog2(NREQ)
) (
    input  wire logic [NREQ-1:0] req_i,
    input  wire logic [IW-1:0]   ptr_i,
    output logic      [NREQ-1:0] gnt_o,
    output logic      [IW-1:0]   idx_o,
    output logic                 any_o
);

    int cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr_i) + k) % NREQ;
            if (!any_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = IW'(cand);
                any_o       = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_share_sched.sv
// alu_share_sched: round-robin time-sharing of one add/sub/mul unit among NREQ requesters.
// Optional ALU_SHARE_PERF_EN adds perf_cnt {MUL, SUB, ADD} saturating completion counters. Rev 1.0
`default_nettype none

module alu_share_sched
    import alu_share_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int DW      = 32,
    parameter int MUL_LAT = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_share_sched_if.slave   bus
`ifdef ALU_SHARE_PERF_EN
    ,
    output logic [3*16-1:0]    perf_cnt
`endif
);

    localparam int          IW       = $clog2(NREQ);
    localparam logic [3:0]  MUL_LAST = 4'(MUL_LAT - 1);

    sched_state_e    state_q;
    logic [3:0]      cnt_q;
    logic [IW-1:0]   rr_ptr_q;
    alu_op_e         op_q;
    logic [DW-1:0]   a_q;
    logic [DW-1:0]   b_q;
    logic [IW-1:0]   id_q;
    logic            rsp_valid_q;
    logic [DW-1:0]   rsp_data_q;
    logic [IW-1:0]   rsp_id_q;
    logic            rsp_err_q;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    alu_op_e         sel_op;
    logic [DW-1:0]   sel_a;
    logic [DW-1:0]   sel_b;
    logic [DW-1:0]   rsp_data_d;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i (bus.req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    always_comb begin
        sel_op = alu_op_e'(bus.req_op[2*gnt_idx +: 2]);
        sel_a  = bus.req_a[DW*gnt_idx +: DW];
        sel_b  = bus.req_b[DW*gnt_idx +: DW];
    end

    // Low DW bits of the wide result are exact for unsigned modulo-2^DW arithmetic.
    assign rsp_data_d = DW'(alu_calc(op_q, CALC_W'(a_q), CALC_W'(b_q)));

    // Accept is combinational so the grant and handshake happen in the same IDLE cycle.
    assign bus.req_ready = (state_q == IDLE && rst_n) ? gnt : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_err   = rsp_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rr_ptr_q    <= IW'(NREQ - 1);
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        op_q     <= sel_op;
                        a_q      <= sel_a;
                        b_q      <= sel_b;
                        id_q     <= gnt_idx;
                        rr_ptr_q <= gnt_idx;
                        cnt_q    <= '0;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (op_q != OP_MUL || cnt_q == MUL_LAST) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= rsp_data_d;
                        rsp_id_q    <= id_q;
                        rsp_err_q   <= (op_q == OP_ILL);
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ALU_SHARE_PERF_EN
    logic [15:0] perf_add_q;
    logic [15:0] perf_sub_q;
    logic [15:0] perf_mul_q;
    logic        rsp_fire;

    assign rsp_fire = (state_q == RESP) && bus.rsp_ready;
    assign perf_cnt = {perf_mul_q, perf_sub_q, perf_add_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_add_q <= '0;
            perf_sub_q <= '0;
            perf_mul_q <= '0;
        end else if (rsp_fire) begin
            case (op_q)
                OP_ADD:  if (perf_add_q != 16'hFFFF) perf_add_q <= perf_add_q + 16'd1;
                OP_SUB:  if (perf_sub_q != 16'hFFFF) perf_sub_q <= perf_sub_q + 16'd1;
                OP_MUL:  if (perf_mul_q != 16'hFFFF) perf_mul_q <= perf_mul_q + 16'd1;
                default: ;
            endcase
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_share_sched.sv
// tb_alu_share_sched: directed stimulus, transaction-level reference model and literal checks.
// Rev 1.0
`default_nettype none

module tb_alu_share_sched;

    localparam int NREQ    = 3;
    localparam int DW      = 32;
    localparam int MUL_LAT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    alu_share_sched_if #(.NREQ(NREQ), .DW(DW)) bus ();

`ifdef ALU_SHARE_PERF_EN
    logic [47:0] perf_cnt;
`endif

    alu_share_sched #(
        .NREQ    (NREQ),
        .DW      (DW),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef ALU_SHARE_PERF_EN
        ,
        .perf_cnt (perf_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one job at a time, a remaining-cycles count, one held response.
    bit              model_on = 1'b0;
    int              m_ptr    = NREQ - 1;
    bit              m_busy   = 1'b0;
    int              m_wait   = 0;
    bit              m_rv     = 1'b0;
    logic [DW-1:0]   m_data   = '0;
    int              m_id     = 0;
    bit              m_err    = 1'b0;
    int              j_op     = 0;
    int              j_id     = 0;
    logic [DW-1:0]   j_a      = '0;
    logic [DW-1:0]   j_b      = '0;
    logic [NREQ-1:0] m_rdy;
    int              m_g;
    int              m_best;
    int              m_dist;

    always @(negedge clk) begin
        if (model_on) begin
            m_rdy  = '0;
            m_g    = -1;
            m_best = NREQ;
            if (rst_n && !m_busy && !m_rv) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (bus.req_valid[i]) begin
                        m_dist = (i - m_ptr - 1 + 2 * NREQ) % NREQ;
                        if (m_dist < m_best) begin
                            m_best = m_dist;
                            m_g    = i;
                        end
                    end
                end
            end
            if (m_g >= 0) m_rdy[m_g] = 1'b1;
            chk("model_req_ready", 64'(bus.req_ready), 64'(m_rdy));
            chk("model_rsp_valid", 64'(bus.rsp_valid), 64'(m_rv));
            if (m_rv) begin
                chk("model_rsp_data", 64'(bus.rsp_data), 64'(m_data));
                chk("model_rsp_id",   64'(bus.rsp_id),   64'(m_id));
                chk("model_rsp_err",  64'(bus.rsp_err),  64'(m_err));
            end
            if (!rst_n) begin
                m_busy = 1'b0;
                m_rv   = 1'b0;
                m_ptr  = NREQ - 1;
            end else if (m_rv) begin
                if (bus.rsp_ready) m_rv = 1'b0;
            end else if (m_busy) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_busy = 1'b0;
                    m_rv   = 1'b1;
                    m_id   = j_id;
                    m_err  = (j_op == 3);
                    case (j_op)
                        0:       m_data = j_a + j_b;
                        1:       m_data = j_a - j_b;
                        2:       m_data = j_a * j_b;
                        default: m_data = '0;
                    endcase
                end
            end else if (m_g >= 0) begin
                j_op   = int'(bus.req_op[2*m_g +: 2]);
                j_a    = bus.req_a[DW*m_g +: DW];
                j_b    = bus.req_b[DW*m_g +: DW];
                j_id   = m_g;
                m_busy = 1'b1;
                m_wait = (j_op == 2) ? MUL_LAT : 1;
                m_ptr  = m_g;
            end
        end
    end

    task automatic drive(input int r, input int op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_valid[r]       = 1'b1;
        bus.req_op[2*r +: 2]   = 2'(op);
        bus.req_a[DW*r +: DW]  = a;
        bus.req_b[DW*r +: DW]  = b;
    endtask

    task automatic wait_grant(input int r, output int t);
        bit ok = 1'b0;
        t = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (bus.req_ready[r]) begin
                t  = cyc;
                ok = 1'b1;
            end
        end
        if (!ok) chk("grant_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_rsp(output int t, output logic [DW-1:0] d, output int id, output bit err);
        bit ok = 1'b0;
        t = 0; d = '0; id = 0; err = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                t   = cyc;
                d   = bus.rsp_data;
                id  = int'(bus.rsp_id);
                err = bus.rsp_err;
                ok  = 1'b1;
            end
        end
        if (!ok) chk("rsp_timeout", 64'(0), 64'(1));
    endtask

    task automatic one_op(input string name, input int r, input int op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [DW-1:0] exp_d, input bit exp_err,
                          input int exp_lat);
        int t0, t1, id;
        logic [DW-1:0] d;
        bit err;
        @(posedge clk); #1;
        drive(r, op, a, b);
        wait_grant(r, t0);
        @(posedge clk); #1;
        bus.req_valid[r] = 1'b0;
        wait_rsp(t1, d, id, err);
        chk({name, "_data"}, 64'(d), 64'(exp_d));
        chk({name, "_id"},   64'(id), 64'(r));
        chk({name, "_err"},  64'(err), 64'(exp_err));
        chk({name, "_lat"},  64'(t1 - t0), 64'(exp_lat));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, id;
        logic [DW-1:0] d;
        bit err;

        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("reset_rsp_data",  64'(bus.rsp_data),  64'(0));
        chk("reset_rsp_id",    64'(bus.rsp_id),    64'(0));
        chk("reset_rsp_err",   64'(bus.rsp_err),   64'(0));
        chk("reset_req_ready", 64'(bus.req_ready), 64'(0));
        model_on = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic ops and latencies
        one_op("add", 0, 0, 32'd10, 32'd2, 32'd12, 1'b0, 2);
        one_op("sub", 1, 1, 32'd2, 32'd10, 32'hFFFF_FFF8, 1'b0, 2);
        one_op("mul", 2, 2, 32'd10, 32'd2, 32'd20, 1'b0, MUL_LAT + 1);

        // Fairness with all requesters continuously valid
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) drive(i, 0, DW'(i), 32'd1);
        for (int n = 0; n < 6; n++) begin
            wait_rsp(t1, d, id, err);
            chk("rr_id",   64'(id), 64'(n % 3));
            chk("rr_data", 64'(d),  64'(n % 3 + 1));
        end
        @(posedge clk); #1;
        bus.req_valid = '0;

        // Result backpressure with a competing request pending
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        drive(0, 0, 32'd7, 32'd8);
        wait_grant(0, t0);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        drive(1, 0, 32'd1, 32'd1);
        wait_rsp(t1, d, id, err);
        chk("bp_first_data", 64'(d), 64'(15));
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(bus.rsp_valid), 64'(1));
            chk("bp_hold_data",  64'(bus.rsp_data),  64'(15));
            chk("bp_hold_id",    64'(bus.rsp_id),    64'(0));
            chk("bp_req_ready",  64'(bus.req_ready), 64'(0));
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        t0 = cyc;
        chk("bp_release_valid", 64'(bus.rsp_valid), 64'(1));
        wait_grant(1, t1);
        chk("bp_next_grant_gap", 64'(t1 - t0), 64'(1));
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        wait_rsp(t1, d, id, err);
        chk("bp_second_data", 64'(d), 64'(2));
        chk("bp_second_id",   64'(id), 64'(1));

        // Illegal opcode, then pointer advance puts requester 1 ahead of 0
        one_op("ill", 0, 3, 32'd5, 32'd5, 32'd0, 1'b1, 2);
        @(posedge clk); #1;
        drive(0, 0, 32'd1, 32'd1);
        drive(1, 0, 32'd2, 32'd2);
        wait_grant(1, t0);
        chk("after_ill_not_req0", 64'(bus.req_ready[0]), 64'(0));
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        wait_rsp(t1, d, id, err);
        chk("after_ill_first_id",   64'(id), 64'(1));
        chk("after_ill_first_data", 64'(d),  64'(4));
        wait_grant(0, t0);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        wait_rsp(t1, d, id, err);
        chk("after_ill_second_id",   64'(id), 64'(0));
        chk("after_ill_second_data", 64'(d),  64'(2));

        // Reset in the middle of a multiply (third EXEC cycle)
        @(posedge clk); #1;
        drive(2, 2, 32'd6, 32'd7);
        wait_grant(2, t0);
        @(posedge clk); #1;
        bus.req_valid[2] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("rst_no_rsp", 64'(bus.rsp_valid), 64'(0));
        end
        @(posedge clk); #1;
        drive(0, 0, 32'd3, 32'd4);
        drive(1, 0, 32'd9, 32'd9);
        @(negedge clk);
        chk("rst_first_grant", 64'(bus.req_ready), 64'(3'b001));
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        wait_rsp(t1, d, id, err);
        chk("rst_add_data", 64'(d),  64'(7));
        chk("rst_add_id",   64'(id), 64'(0));
        wait_grant(1, t0);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        wait_rsp(t1, d, id, err);
        chk("rst_second_data", 64'(d), 64'(18));
        @(posedge clk); #1;
`ifdef ALU_SHARE_PERF_EN
        chk("perf_cnt", 64'(perf_cnt), 64'({16'd0, 16'd0, 16'd2}));
`endif
        repeat (3) @(posedge clk);
        model_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
